// File: rtl/ram_arb_pkg.sv
// Shared types and default constants for the data-RAM port arbiter and its
// keyboard code FIFO.
package ram_arb_pkg;

  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_OFFSET_ADDR = 0;
  localparam int DEF_KB_ADDR     = 1;
  localparam int DEF_OFFSET_W    = 10;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_STARVE_MAX  = 8;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE
  } arb_state_t;

  // Low 10 bits of a keyboard MMIO load.
  typedef struct packed {
    logic       overflow;
    logic       nonempty;
    logic [7:0] code;
  } kb_status_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// CPU load/store port into the shared data RAM, with the stall back-pressure.
interface ram_port_arbiter_if;

  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall
  );

  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall
  );

endinterface

// File: rtl/ram_port_arbiter_kb_code_fifo.sv
// Small FIFO of PS/2 key codes; head is visible combinationally, push and pop
// in the same cycle are both honoured even when full.
module kb_code_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port data RAM owner: CPU loads/stores, frame-synchronous sprite offset
// snapshot with bounded starvation, and a FIFO-backed keyboard MMIO word.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int OFFSET_ADDR = DEF_OFFSET_ADDR,
  parameter int KB_ADDR     = DEF_KB_ADDR,
  parameter int OFFSET_W    = DEF_OFFSET_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int STARVE_MAX  = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   cpu,
  input  logic                kb_valid,
  input  logic [7:0]          kb_code,
  input  logic                frame_start,
  output logic [OFFSET_W-1:0] offset,
  output logic                kb_overflow,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata
);

  localparam int WAIT_W = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(STARVE_MAX - 1);
  localparam logic [ADDR_W-1:0] OFFSET_WORD = ADDR_W'(OFFSET_ADDR);
  localparam logic [ADDR_W-1:0] KB_WORD     = ADDR_W'(KB_ADDR);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic [ADDR_W-1:0] cpu_word;
  logic              is_kb, cpu_busy, snap, stall;
  logic              kb_load, kb_pop, kb_drop;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_head;
  kb_status_t        kb_status;

  assign cpu_word = cpu.cpu_addr[ADDR_W+1:2];
  assign is_kb    = (cpu_word == KB_WORD);
  assign cpu_busy = (cpu.cpu_we | cpu.cpu_re) & ~is_kb;
  assign wait_inc = wait_q + WAIT_W'(1);

  wire unused_addr_bits = ^{cpu.cpu_addr[31:ADDR_W+2], cpu.cpu_addr[1:0]};

  // NOTE: every signal driven here gets a default first so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    snap    = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: if (frame_start) state_d = PEND;
      PEND: begin
        // frame_start is ignored here: a pending snapshot absorbs it.
        if (!cpu_busy) begin
          snap    = 1'b1;
          state_d = IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_LIMIT) state_d = FORCE;
        end
      end
      FORCE: begin
        stall   = 1'b1;
        snap    = 1'b1;
        state_d = IDLE;
        wait_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign ram_addr  = snap ? OFFSET_WORD : cpu_word;
  assign ram_we    = cpu.cpu_we & ~is_kb & ~stall;
  assign ram_wdata = cpu.cpu_wdata;

  assign kb_load = cpu.cpu_re & is_kb & ~stall;
  assign kb_pop  = kb_load & ~fifo_empty;
  assign kb_drop = kb_valid & fifo_full & ~kb_pop;

  kb_code_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_kb_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (kb_valid),
    .pop   (kb_pop),
    .din   (kb_code),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign kb_status.overflow = kb_overflow;
  assign kb_status.nonempty = ~fifo_empty;
  assign kb_status.code     = fifo_empty ? 8'h00 : fifo_head;

  assign cpu.cpu_rdata = is_kb ? 32'(kb_status) : ram_rdata;
  assign cpu.cpu_stall = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      offset      <= '0;
      kb_overflow <= 1'b0;
    end else begin
      if (snap) offset <= ram_rdata[OFFSET_W-1:0];
      // A drop in the same cycle as a clearing load leaves the flag set.
      if (kb_drop)      kb_overflow <= 1'b1;
      else if (kb_load) kb_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32-word RAM model.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        kb_valid;
  logic [7:0]  kb_code;
  logic        frame_start;
  logic [9:0]  offset;
  logic        kb_overflow;
  logic        ram_we;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt;

  ram_port_arbiter_if cpu ();

  ram_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .cpu         (cpu),
    .kb_valid    (kb_valid),
    .kb_code     (kb_code),
    .frame_start (frame_start),
    .offset      (offset),
    .kb_overflow (kb_overflow),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu.cpu_we    = 1'b0;
    cpu.cpu_re    = 1'b0;
    cpu.cpu_addr  = '0;
    cpu.cpu_wdata = '0;
  endtask

  task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data);
    cpu.cpu_we    = 1'b1;
    cpu.cpu_addr  = addr;
    cpu.cpu_wdata = data;
    tick();
    cpu_idle();
  endtask

  task automatic push(input logic [7:0] code);
    kb_valid = 1'b1;
    kb_code  = code;
    tick();
    kb_valid = 1'b0;
  endtask

  task automatic kb_load(input string tag, input logic [31:0] exp);
    cpu.cpu_re   = 1'b1;
    cpu.cpu_addr = 32'h4;
    @(negedge clk);
    check(tag, cpu.cpu_rdata, exp);
    tick();
    cpu_idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= 32'hCAFE_0000 + 32'(i);
    reset       = 1'b1;
    kb_valid    = 1'b0;
    kb_code     = '0;
    frame_start = 1'b0;
    cpu_idle();
    tick();
    tick();
    @(negedge clk);
    check("rst_offset", 32'(offset), 32'h0);
    check("rst_ovf", 32'(kb_overflow), 32'h0);
    check("rst_stall", 32'(cpu.cpu_stall), 32'h0);
    tick();
    reset = 1'b0;

    // Idle CPU: snapshot taken on the first PEND cycle.
    cpu.cpu_we    = 1'b1;
    cpu.cpu_addr  = 32'h0;
    cpu.cpu_wdata = 32'h0000_0123;
    @(negedge clk);
    check("st_ram_we", 32'(ram_we), 32'h1);
    tick();
    cpu_idle();
    check("st_mem0", mem[0], 32'h0000_0123);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("snap_addr", 32'(ram_addr), 32'h0);
    check("snap_nostall", 32'(cpu.cpu_stall), 32'h0);
    tick();
    @(negedge clk);
    check("snap_offset", 32'(offset), 32'h123);

    // Loads every cycle: forced snapshot stalls exactly cycle 8.
    cpu_store(32'h0, 32'h0000_02AB);
    stall_cnt = 0;
    for (int k = 0; k < 13; k++) begin
      cpu.cpu_re   = 1'b1;
      cpu.cpu_addr = 32'(8 + (k % 8)) << 2;
      frame_start  = (k == 0) || (k == 4);
      @(negedge clk);
      check($sformatf("force_stall_k%0d", k), 32'(cpu.cpu_stall), (k == 8) ? 32'h1 : 32'h0);
      if (cpu.cpu_stall) stall_cnt++;
      if (k != 8) check($sformatf("force_rdata_k%0d", k), cpu.cpu_rdata, 32'hCAFE_0000 + 32'(8 + (k % 8)));
      if (k == 8) check("force_offset_old", 32'(offset), 32'h123);
      if (k == 9) check("force_offset_new", 32'(offset), 32'h2AB);
      tick();
    end
    frame_start = 1'b0;
    cpu_idle();
    check("force_stall_count", 32'(stall_cnt), 32'h1);

    // Keyboard pops in order, then empty.
    push(8'h1C);
    push(8'h23);
    kb_load("kb_pop0", 32'h11C);
    kb_load("kb_pop1", 32'h123);
    kb_load("kb_empty", 32'h000);

    // Overflow on fifth push; cleared by the first load.
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    @(negedge clk);
    check("ovf_set", 32'(kb_overflow), 32'h1);
    tick();
    kb_load("ovf_pop0", 32'h310);
    kb_load("ovf_pop1", 32'h111);
    kb_load("ovf_pop2", 32'h112);
    kb_load("ovf_pop3", 32'h113);
    kb_load("ovf_empty", 32'h000);

    // Full FIFO: simultaneous push and pop.
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    kb_valid = 1'b1;
    kb_code  = 8'h44;
    kb_load("full_pp_head", 32'h140);
    kb_valid = 1'b0;
    @(negedge clk);
    check("full_pp_ovf", 32'(kb_overflow), 32'h0);
    tick();
    kb_load("full_pp_1", 32'h141);
    kb_load("full_pp_2", 32'h142);
    kb_load("full_pp_3", 32'h143);
    kb_load("full_pp_4", 32'h144);
    kb_load("full_pp_empty", 32'h000);

    // Reset during PEND discards the snapshot and the FIFO.
    cpu_store(32'h0, 32'h0000_0155);
    push(8'h55);
    cpu.cpu_re   = 1'b1;
    cpu.cpu_addr = 32'h20;
    frame_start  = 1'b1;
    tick();
    frame_start  = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_pend_offset", 32'(offset), 32'h0);
    stall_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu.cpu_stall) stall_cnt++;
      tick();
    end
    check("rst_pend_nostall", 32'(stall_cnt), 32'h0);
    check("rst_pend_offset2", 32'(offset), 32'h0);
    cpu_idle();
    kb_load("rst_fifo_empty", 32'h000);

    cpu.cpu_we    = 1'b1;
    cpu.cpu_addr  = 32'h4;
    cpu.cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("kb_store_we", 32'(ram_we), 32'h0);
    tick();
    cpu_idle();
    check("kb_store_mem1", mem[1], 32'hCAFE_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Owns the single-port data RAM that the ARM core shares with the peripherals.
- Arbitrates each cycle between CPU load/store accesses and a frame-synchronous snapshot read of the sprite offset word. The snapshot gives the VGA path a tear-free offset.
- Decodes a memory-mapped keyboard word that is backed by a small FIFO rather than by RAM, so the CPU does not lose keystrokes between polls.
- Sits between the processor, the PS/2 keyboard controller, the VGA/sprite path and the RAM array.

Parameters:
- ADDR_W, 5, word-address width of the RAM (32 words).
- OFFSET_ADDR, 0, word address of the sprite offset word.
- KB_ADDR, 1, word address of the keyboard MMIO word.
- OFFSET_W, 10, width of the snapshot offset output.
- FIFO_DEPTH, 4, keyboard code FIFO depth; must be a power of 2 and at least 2.
- STARVE_MAX, 8, maximum number of cycles a pending snapshot waits before it preempts the CPU.

Ports:
- clk  in  1  system clock (the 25 MHz pixel/CPU clock).
- reset  in  1  synchronous, active-high reset.
- cpu_we  in  1  CPU store strobe.
- cpu_re  in  1  CPU load strobe.
- cpu_addr  in  32  CPU byte address; word = cpu_addr[ADDR_W+1:2].
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data (combinational).
- cpu_stall  out  1  CPU must hold its access this cycle.
- kb_valid  in  1  one-cycle pulse: new key code available.
- kb_code  in  8  key code, qualified by kb_valid.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- offset  out  OFFSET_W  registered sprite offset snapshot.
- kb_overflow  out  1  sticky flag: a key code was dropped.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data (combinational read).

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values:
  - offset = 0, kb_overflow = 0, cpu_stall = 0.
  - FIFO empty (read/write pointers and count = 0), wait_cnt = 0.
  - State = IDLE.
  - Reset asserted mid-operation discards any pending snapshot and all FIFO contents.
- Port-busy definition: cpu_busy = (cpu_we | cpu_re) and the decoded word is not KB_ADDR.
- State machine:
  - IDLE: on frame_start, go to PEND.
  - PEND: if !cpu_busy, grant the snapshot: ram_addr = OFFSET_ADDR, offset <= ram_rdata[OFFSET_W-1:0], go to IDLE. Otherwise wait_cnt++. When wait_cnt reaches STARVE_MAX-1 with the CPU still busy, go to FORCE.
  - FORCE: cpu_stall = 1 for exactly one cycle; snapshot granted; offset latched; go to IDLE; wait_cnt = 0.
  - frame_start while in PEND or FORCE is merged: no second snapshot, wait_cnt is not reset.
- CPU path when not stalled:
  - ram_addr = CPU word address.
  - ram_we = cpu_we and (word != KB_ADDR).
  - cpu_rdata = ram_rdata.
  - Zero added latency.
- CPU path when stalled: ram_we = 0. cpu_rdata is don't-care; the CPU repeats the access next cycle.
- Store to word OFFSET_ADDR: writes RAM only. offset changes only at the next snapshot.
- Keyboard MMIO (word KB_ADDR), decoded even when stalled = 0:
  - Load: cpu_rdata = {22'b0, kb_overflow, nonempty, head_code[7:0]}. If nonempty, pop the head at the clock edge. If empty, head_code reads as 0 and nothing is popped. A load also clears kb_overflow at the edge.
  - Store to KB_ADDR: ignored.
  - A load of KB_ADDR during a FORCE cycle is stalled, so no pop occurs that cycle.
- FIFO:
  - kb_valid pushes kb_code when not full.
  - Push while full with no same-cycle pop: code is dropped and kb_overflow <= 1. If a clear (KB load) happens in the same cycle as a drop, the set wins.
  - Push and pop in the same cycle: both occur, including when full. Count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package ram_arb_pkg:
  - arb_state_t enum {IDLE, PEND, FORCE}.
  - Default address constants.
  - kb_status_t packed struct {overflow, nonempty, code}.
- Sub-module kb_code_fifo: parameterised depth, 8-bit data; push/pop/full/empty/head outputs.
- The arbiter FSM, address decode and RAM muxing stay in ram_port_arbiter.

Test Plan:
- Reset, then CPU store 0x0000_0123 to byte addr 0x0 and pulse frame_start with CPU idle → offset = 0x123 on the next cycle; cpu_stall never asserted.
- CPU issues loads every cycle, then frame_start → cpu_stall high for exactly one cycle, 8 cycles after frame_start; offset updated in that cycle; CPU load data is correct in all other cycles.
- Push codes 0x1C, 0x23, then load byte addr 0x4 three times → rdata 0x11C, then 0x123, then 0x000; FIFO empty afterwards.
- Push 5 codes (0x10..0x14) with no reads → kb_overflow = 1. Four loads return 0x310 (overflow bit still set at the first read), then 0x111, 0x112, 0x113; overflow is cleared after the first load.
- FIFO full, with kb_valid and a KB load in the same cycle → the load returns the old head, the new code is enqueued at the tail, overflow stays 0, count stays 4.
- Snapshot in PEND when reset is asserted → state IDLE, offset = 0, no stall on the following cycles; a store to KB_ADDR leaves the RAM unchanged (ram_we stays 0).
